// File: rtl/regfile_sb.sv
// Parametrised two-write / two-read register file with a per-register busy
// scoreboard that raises the issue stall on RAW/WAW hazards.
module regfile_sb #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 4,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [DATA_W-1:0] wa_data,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] ra1_addr,
    input  logic [ADDR_W-1:0] ra2_addr,
    output logic [DATA_W-1:0] rd1_data,
    output logic [DATA_W-1:0] rd2_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_dst,
    input  logic [ADDR_W-1:0] issue_src1,
    input  logic [ADDR_W-1:0] issue_src2,
    input  logic              issue_has_dst,
    output logic              stall,
    output logic [DEPTH-1:0]  busy
);

    logic [DATA_W-1:0] regs_reg [DEPTH];
    logic [DEPTH-1:0]  busy_reg;
    logic [DEPTH-1:0]  hit_a;
    logic [DEPTH-1:0]  hit_b;
    logic [DEPTH-1:0]  clr;
    logic [DEPTH-1:0]  set;
    logic [DEPTH-1:0]  eff;
    logic              accept;

    logic [ADDR_W-1:0]            ra [2];
    logic [1:0][DATA_W-1:0]       rd_val;

    // A hardwired zero register never sees a write hit, so it stays 0 and never busy.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
        localparam bit HARD_ZERO = (ZERO_REG != 0) && (gi == 0);
        assign hit_a[gi] = !HARD_ZERO && we_a && (wa_addr == ADDR_W'(gi));
        assign hit_b[gi] = !HARD_ZERO && we_b && (wb_addr == ADDR_W'(gi));
        assign clr[gi]   = hit_a[gi] | hit_b[gi];
        assign set[gi]   = !HARD_ZERO && accept && issue_has_dst && (issue_dst == ADDR_W'(gi));
        assign eff[gi]   = busy_reg[gi] & ~((BYPASS != 0) ? clr[gi] : 1'b0);
    end

    assign stall  = issue_valid & (eff[issue_src1] | eff[issue_src2] |
                                   (issue_has_dst & eff[issue_dst]));
    assign accept = issue_valid & ~stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
            busy_reg <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (hit_b[i]) begin
                    regs_reg[i] <= wb_data;
                end else if (hit_a[i]) begin
                    regs_reg[i] <= wa_data;
                end
            end
            // Set is OR-ed after the clear so a same-edge issue keeps the bit.
            busy_reg <= (busy_reg & ~clr) | set;
        end
    end

    assign ra[0] = ra1_addr;
    assign ra[1] = ra2_addr;

    // Forwarding is suppressed during reset so reads return the cleared contents.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        assign rd_val[gi] = ((BYPASS != 0) && !rst && hit_b[ra[gi]]) ? wb_data :
                            ((BYPASS != 0) && !rst && hit_a[ra[gi]]) ? wa_data :
                            regs_reg[ra[gi]];
    end

    assign rd1_data = rd_val[0];
    assign rd2_data = rd_val[1];
    assign busy     = busy_reg;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: three configurations driven in parallel, directed
// vector table, a zero-register sequence and a randomized reference-model phase.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_a, we_b, issue_valid, issue_has_dst;
    logic [3:0]  wa_addr, wb_addr, ra1_addr, ra2_addr, issue_dst, issue_src1, issue_src2;
    logic [15:0] wa_data, wb_data;

    logic [7:0]  rd1_0, rd2_0, rd1_1, rd2_1;
    logic [15:0] rd1_2, rd2_2;
    logic        stall_0, stall_1, stall_2;
    logic [3:0]  busy_0, busy_1;
    logic [15:0] busy_2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(8), .DEPTH(4), .ZERO_REG(0), .BYPASS(1)) u0 (
        .clk(clk), .rst(rst),
        .we_a(we_a), .wa_addr(wa_addr[1:0]), .wa_data(wa_data[7:0]),
        .we_b(we_b), .wb_addr(wb_addr[1:0]), .wb_data(wb_data[7:0]),
        .ra1_addr(ra1_addr[1:0]), .ra2_addr(ra2_addr[1:0]),
        .rd1_data(rd1_0), .rd2_data(rd2_0),
        .issue_valid(issue_valid), .issue_dst(issue_dst[1:0]),
        .issue_src1(issue_src1[1:0]), .issue_src2(issue_src2[1:0]),
        .issue_has_dst(issue_has_dst), .stall(stall_0), .busy(busy_0));

    regfile_sb #(.DATA_W(8), .DEPTH(4), .ZERO_REG(0), .BYPASS(0)) u1 (
        .clk(clk), .rst(rst),
        .we_a(we_a), .wa_addr(wa_addr[1:0]), .wa_data(wa_data[7:0]),
        .we_b(we_b), .wb_addr(wb_addr[1:0]), .wb_data(wb_data[7:0]),
        .ra1_addr(ra1_addr[1:0]), .ra2_addr(ra2_addr[1:0]),
        .rd1_data(rd1_1), .rd2_data(rd2_1),
        .issue_valid(issue_valid), .issue_dst(issue_dst[1:0]),
        .issue_src1(issue_src1[1:0]), .issue_src2(issue_src2[1:0]),
        .issue_has_dst(issue_has_dst), .stall(stall_1), .busy(busy_1));

    regfile_sb #(.DATA_W(16), .DEPTH(16), .ZERO_REG(1), .BYPASS(1)) u2 (
        .clk(clk), .rst(rst),
        .we_a(we_a), .wa_addr(wa_addr), .wa_data(wa_data),
        .we_b(we_b), .wb_addr(wb_addr), .wb_data(wb_data),
        .ra1_addr(ra1_addr), .ra2_addr(ra2_addr),
        .rd1_data(rd1_2), .rd2_data(rd2_2),
        .issue_valid(issue_valid), .issue_dst(issue_dst),
        .issue_src1(issue_src1), .issue_src2(issue_src2),
        .issue_has_dst(issue_has_dst), .stall(stall_2), .busy(busy_2));

    typedef struct packed {
        logic        we_a;
        logic [3:0]  wa;
        logic [15:0] wda;
        logic        we_b;
        logic [3:0]  wb;
        logic [15:0] wdb;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic        iv;
        logic        hd;
        logic [3:0]  dst;
        logic [3:0]  s1;
        logic [3:0]  s2;
    } stim_t;

    typedef struct packed {
        stim_t       s;
        logic [15:0] rd_bp;
        logic [15:0] rd_nb;
        logic        st_bp;
        logic        st_nb;
        logic [3:0]  bz_bp;
        logic [3:0]  bz_nb;
    } vec_t;

    vec_t tbl[$];

    int dw_c[3] = '{8, 8, 16};
    int dp_c[3] = '{4, 4, 16};
    int zr_c[3] = '{0, 0, 1};
    int bp_c[3] = '{1, 0, 1};

    logic [15:0] mregs [3][16];
    bit          mbusy [3][16];

    function automatic stim_t mk(logic wea, logic [3:0] wa, logic [15:0] wda,
                                 logic web, logic [3:0] wb, logic [15:0] wdb,
                                 logic [3:0] ra1, logic iv, logic hd,
                                 logic [3:0] dst, logic [3:0] s1, logic [3:0] s2);
        stim_t s;
        s.we_a = wea; s.wa = wa; s.wda = wda;
        s.we_b = web; s.wb = wb; s.wdb = wdb;
        s.ra1 = ra1; s.ra2 = 4'd0;
        s.iv = iv; s.hd = hd; s.dst = dst; s.s1 = s1; s.s2 = s2;
        return s;
    endfunction

    function automatic void add(stim_t s, logic [15:0] rb, logic [15:0] rn,
                                logic sb, logic sn, logic [3:0] bb, logic [3:0] bn);
        vec_t v;
        v.s = s; v.rd_bp = rb; v.rd_nb = rn; v.st_bp = sb; v.st_nb = sn;
        v.bz_bp = bb; v.bz_nb = bn;
        tbl.push_back(v);
    endfunction

    task automatic apply(input stim_t s);
        we_a = s.we_a; wa_addr = s.wa; wa_data = s.wda;
        we_b = s.we_b; wb_addr = s.wb; wb_data = s.wdb;
        ra1_addr = s.ra1; ra2_addr = s.ra2;
        issue_valid = s.iv; issue_has_dst = s.hd;
        issue_dst = s.dst; issue_src1 = s.s1; issue_src2 = s.s2;
    endtask

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h", nm, k, act, exp);
        end
    endtask

    function automatic logic [15:0] get_rd1(int k);
        case (k)
            0:       return {8'h00, rd1_0};
            1:       return {8'h00, rd1_1};
            default: return rd1_2;
        endcase
    endfunction

    function automatic logic [15:0] get_rd2(int k);
        case (k)
            0:       return {8'h00, rd2_0};
            1:       return {8'h00, rd2_1};
            default: return rd2_2;
        endcase
    endfunction

    function automatic logic get_stall(int k);
        case (k)
            0:       return stall_0;
            1:       return stall_1;
            default: return stall_2;
        endcase
    endfunction

    function automatic logic [15:0] get_busy(int k);
        case (k)
            0:       return {12'h000, busy_0};
            1:       return {12'h000, busy_1};
            default: return busy_2;
        endcase
    endfunction

    // Reference model: architectural register/busy arrays updated from the rules.
    function automatic int am(int k, logic [3:0] a);
        return int'(a) % dp_c[k];
    endfunction

    function automatic logic [15:0] dm(int k, logic [15:0] d);
        return (dw_c[k] == 16) ? d : {8'h00, d[7:0]};
    endfunction

    function automatic bit wr_a(int k, int a);
        return we_a && (am(k, wa_addr) == a) && !(zr_c[k] != 0 && a == 0);
    endfunction

    function automatic bit wr_b(int k, int a);
        return we_b && (am(k, wb_addr) == a) && !(zr_c[k] != 0 && a == 0);
    endfunction

    function automatic logic [15:0] m_read(int k, logic [3:0] addr);
        int a = am(k, addr);
        if (rst || (zr_c[k] != 0 && a == 0)) return 16'h0;
        if (bp_c[k] != 0) begin
            if (wr_b(k, a)) return dm(k, wb_data);
            if (wr_a(k, a)) return dm(k, wa_data);
        end
        return mregs[k][a];
    endfunction

    function automatic bit m_eff(int k, logic [3:0] addr);
        int a = am(k, addr);
        return mbusy[k][a] && !(bp_c[k] != 0 && (wr_a(k, a) || wr_b(k, a)));
    endfunction

    function automatic bit m_stall(int k);
        return issue_valid && (m_eff(k, issue_src1) || m_eff(k, issue_src2) ||
                               (issue_has_dst && m_eff(k, issue_dst)));
    endfunction

    function automatic logic [15:0] m_busy(int k);
        logic [15:0] v = '0;
        for (int a = 0; a < dp_c[k]; a++) v[a] = mbusy[k][a];
        return v;
    endfunction

    function automatic void m_clear();
        for (int k = 0; k < 3; k++)
            for (int a = 0; a < 16; a++) begin
                mregs[k][a] = '0;
                mbusy[k][a] = 1'b0;
            end
    endfunction

    function automatic void m_step(int k);
        bit acc;
        int d;
        if (rst) begin
            for (int a = 0; a < 16; a++) begin
                mregs[k][a] = '0;
                mbusy[k][a] = 1'b0;
            end
            return;
        end
        acc = issue_valid && !m_stall(k);
        d   = am(k, issue_dst);
        for (int a = 0; a < dp_c[k]; a++) begin
            bit setb = acc && issue_has_dst && (a == d) && !(zr_c[k] != 0 && a == 0);
            bit clrb = wr_a(k, a) || wr_b(k, a);
            if (wr_b(k, a))      mregs[k][a] = dm(k, wb_data);
            else if (wr_a(k, a)) mregs[k][a] = dm(k, wa_data);
            mbusy[k][a] = (mbusy[k][a] && !clrb) || setb;
        end
    endfunction

    task automatic chk_zero(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk({tag, "_rd1"}, k, get_rd1(k), 0);
            chk({tag, "_rd2"}, k, get_rd2(k), 0);
            chk({tag, "_stall"}, k, get_stall(k), 0);
            chk({tag, "_busy"}, k, get_busy(k), 0);
        end
    endtask

    task automatic randomize_inputs();
        we_a = ($urandom_range(0, 2) == 0); wa_addr = 4'($urandom_range(0, 15));
        wa_data = 16'($urandom);
        we_b = ($urandom_range(0, 2) == 0); wb_addr = 4'($urandom_range(0, 15));
        wb_data = 16'($urandom);
        ra1_addr = 4'($urandom_range(0, 15)); ra2_addr = 4'($urandom_range(0, 15));
        issue_valid = ($urandom_range(0, 3) != 0); issue_has_dst = ($urandom_range(0, 3) != 0);
        issue_dst = 4'($urandom_range(0, 15));
        issue_src1 = 4'($urandom_range(0, 15)); issue_src2 = 4'($urandom_range(0, 15));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        apply('0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        stim_t s;
        rst = 1'b1;
        apply('0);

        // Reset out of a dirty state: build random contents, then reset mid-cycle.
        @(posedge clk); #1; rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            randomize_inputs();
            @(posedge clk); #1;
        end
        randomize_inputs();
        issue_valid = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk); chk_zero("rst_hold");
        @(posedge clk); #1;
        randomize_inputs();
        issue_valid = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_stall_iv", k, get_stall(k), 0);
            chk("rst_busy_iv", k, get_busy(k), 0);
            chk("rst_rd1_iv", k, get_rd1(k), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        apply('0);
        @(posedge clk); #1;
        @(negedge clk); chk_zero("post_rst");

        // Directed table: expected rd1/stall/busy for the bypass and no-bypass units.
        add(mk(1,4'd2,16'h5A,0,4'd0,16'h0, 4'd2, 0,0,4'd0,4'd0,4'd0), 16'h5A,16'h00, 0,0, 4'h0,4'h0);
        add(mk(0,4'd0,16'h0 ,0,4'd0,16'h0, 4'd2, 0,0,4'd0,4'd0,4'd0), 16'h5A,16'h5A, 0,0, 4'h0,4'h0);
        add(mk(1,4'd3,16'h11,1,4'd3,16'h22,4'd3, 0,0,4'd0,4'd0,4'd0), 16'h22,16'h00, 0,0, 4'h0,4'h0);
        add(mk(0,4'd0,16'h0 ,0,4'd0,16'h0, 4'd3, 0,0,4'd0,4'd0,4'd0), 16'h22,16'h22, 0,0, 4'h0,4'h0);
        add(mk(0,4'd0,16'h0 ,0,4'd0,16'h0, 4'd0, 1,1,4'd1,4'd0,4'd0), 16'h00,16'h00, 0,0, 4'h0,4'h0);
        add(mk(0,4'd0,16'h0 ,0,4'd0,16'h0, 4'd1, 1,0,4'd0,4'd1,4'd0), 16'h00,16'h00, 1,1, 4'h2,4'h2);
        add(mk(0,4'd0,16'h0 ,1,4'd1,16'h77,4'd1, 1,0,4'd0,4'd1,4'd0), 16'h77,16'h00, 0,1, 4'h2,4'h2);
        add(mk(0,4'd0,16'h0 ,0,4'd0,16'h0, 4'd1, 1,0,4'd0,4'd1,4'd0), 16'h77,16'h77, 0,0, 4'h0,4'h0);
        add(mk(1,4'd1,16'h33,0,4'd0,16'h0, 4'd1, 1,1,4'd1,4'd0,4'd0), 16'h33,16'h77, 0,0, 4'h0,4'h0);
        add(mk(0,4'd0,16'h0 ,1,4'd1,16'h44,4'd1, 1,1,4'd1,4'd0,4'd0), 16'h44,16'h33, 0,1, 4'h2,4'h2);
        add(mk(0,4'd0,16'h0 ,0,4'd0,16'h0, 4'd1, 0,0,4'd0,4'd0,4'd0), 16'h44,16'h44, 0,0, 4'h2,4'h0);
        add(mk(0,4'd0,16'h0 ,0,4'd0,16'h0, 4'd1, 1,0,4'd0,4'd1,4'd0), 16'h44,16'h44, 1,0, 4'h2,4'h0);
        add(mk(1,4'd1,16'h99,0,4'd0,16'h0, 4'd1, 0,0,4'd0,4'd0,4'd0), 16'h99,16'h44, 0,0, 4'h2,4'h0);
        add(mk(0,4'd0,16'h0 ,0,4'd0,16'h0, 4'd1, 0,0,4'd0,4'd0,4'd0), 16'h99,16'h99, 0,0, 4'h0,4'h0);

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].s);
            @(negedge clk);
            chk($sformatf("tbl%0d_rd1", i), 0, get_rd1(0), tbl[i].rd_bp);
            chk($sformatf("tbl%0d_rd1", i), 1, get_rd1(1), tbl[i].rd_nb);
            chk($sformatf("tbl%0d_stall", i), 0, get_stall(0), tbl[i].st_bp);
            chk($sformatf("tbl%0d_stall", i), 1, get_stall(1), tbl[i].st_nb);
            chk($sformatf("tbl%0d_busy", i), 0, get_busy(0), tbl[i].bz_bp);
            chk($sformatf("tbl%0d_busy", i), 1, get_busy(1), tbl[i].bz_nb);
            @(posedge clk); #1;
        end

        // Hardwired zero register on the 16-bit, 16-deep unit.
        do_reset();
        s = mk(1,4'd0,16'hFFFF,1,4'd15,16'hBEEF,4'd0, 1,1,4'd0,4'd0,4'd0); s.ra2 = 4'd15;
        apply(s);
        @(negedge clk);
        chk("z_rd1_bypass", 2, get_rd1(2), 16'h0);
        chk("z_rd2_bypass", 2, get_rd2(2), 16'hBEEF);
        chk("z_stall_dst0", 2, get_stall(2), 0);
        @(posedge clk); #1;
        s = mk(0,4'd0,16'h0,0,4'd0,16'h0,4'd0, 1,0,4'd0,4'd0,4'd15); s.ra2 = 4'd15;
        apply(s);
        @(negedge clk);
        chk("z_rd1", 2, get_rd1(2), 16'h0);
        chk("z_rd2", 2, get_rd2(2), 16'hBEEF);
        chk("z_stall_src0", 2, get_stall(2), 0);
        chk("z_busy", 2, get_busy(2), 16'h0);
        @(posedge clk); #1;
        apply(mk(0,4'd0,16'h0,0,4'd0,16'h0,4'd0, 1,1,4'd15,4'd0,4'd0));
        @(posedge clk); #1;
        apply(mk(0,4'd0,16'h0,0,4'd0,16'h0,4'd0, 1,0,4'd0,4'd15,4'd0));
        @(negedge clk);
        chk("z_stall_r15", 2, get_stall(2), 1);
        chk("z_busy_r15", 2, get_busy(2), 16'h8000);
        @(posedge clk); #1;

        // Randomized phase against the reference model, with occasional resets.
        do_reset();
        m_clear();
        for (int i = 0; i < 600; i++) begin
            randomize_inputs();
            rst = ($urandom_range(0, 39) == 0);
            if (rst) m_clear();
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                chk("rnd_rd1", k, get_rd1(k), m_read(k, ra1_addr));
                chk("rnd_rd2", k, get_rd2(k), m_read(k, ra2_addr));
                chk("rnd_stall", k, get_stall(k), m_stall(k));
                chk("rnd_busy", k, get_busy(k), m_busy(k));
                m_step(k);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised successor to the 8-bit, 4-entry register file: configurable data width and depth, two write ports, two read ports, optional write-to-read bypass, optional hardwired zero register, and an asynchronous reset. It adds a per-register busy scoreboard that sets a register's bit when an instruction issues to it and clears the bit on writeback. It also produces the issue stall for RAW/WAW hazards. It sits between decode (issue side) and the execute/memory writeback paths of the datapath.

## Interface
- DATA_W, 8, register width in bits
- DEPTH, 4, number of registers (power of two, ≥2); ADDR_W = $clog2(DEPTH)
- ZERO_REG, 0, 1 = register 0 always reads 0, ignores writes, never busy
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports and used to mask stall
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- we_a  input  1  write enable, port A (execute writeback)
- wa_addr  input  ADDR_W  write address A
- wa_data  input  DATA_W  write data A
- we_b  input  1  write enable, port B (memory writeback)
- wb_addr  input  ADDR_W  write address B
- wb_data  input  DATA_W  write data B
- ra1_addr, ra2_addr  input  ADDR_W  read addresses
- rd1_data, rd2_data  output  DATA_W  combinational read data
- issue_valid  input  1  decode presents an instruction
- issue_dst, issue_src1, issue_src2  input  ADDR_W  destination / sources of issuing instruction
- issue_has_dst  input  1  instruction writes issue_dst
- stall  output  1  combinational; issue not accepted this cycle
- busy  output  DEPTH  registered scoreboard bits

## Operation
- Reset (async assert): all registers = 0, busy = 0. Outputs during reset: rd*_data = 0, stall = 0 when issue_valid = 0.
- Write: on clk edge, we_a writes wa_data to wa_addr; we_b writes wb_data to wb_addr. Same address both ports: port B wins.
- ZERO_REG=1: writes to address 0 dropped; reads of 0 return 0; busy[0] held 0.
- Read: rd_n = registers[ra_n]. If BYPASS=1 and a write enable targets ra_n this cycle, rd_n = that write data (B over A). BYPASS=0: old contents until next edge.
- Clear set: clr[i] = (we_a & wa_addr==i) | (we_b & wb_addr==i).
- Effective busy: eff[i] = busy[i] & ~(BYPASS ? clr[i] : 0).
- stall = issue_valid & (eff[src1] | eff[src2] | (issue_has_dst & eff[dst])); source/dst at address 0 never stalls when ZERO_REG=1.
- Accept = issue_valid & ~stall. On edge: busy[i] <= (busy[i] & ~clr[i]) | (accept & issue_has_dst & issue_dst==i). Set beats clear on the same index.
- Write to a non-busy register is legal, updates data, busy unchanged (stays 0).

## Timing
- Read latency 0 (combinational); write visible to rd_n combinationally same cycle only with BYPASS=1, otherwise the cycle after the edge.
- busy updates one edge after accept/writeback; stall is combinational from current busy and current writes.
- Back-to-back: issue to r at cycle N, writeback to r at cycle N+k, dependent issue accepted at N+k (BYPASS=1) or N+k+1 (BYPASS=0).
- Reset mid-operation: state cleared immediately, no pending writes survive; first post-deassert edge behaves as from idle.

## Test plan
- Reset with random state -> all rd_data = 0, busy = 0, stall = 0 in reset and first cycle after.
- we_a=1 wa_addr=2 wa_data=0x5A, read ra1=2 same cycle -> rd1=0x5A (BYPASS=1) / old value 0x00 (BYPASS=0); rd1=0x5A next cycle both.
- we_a/we_b both to addr 3 with 0x11/0x22 -> reg3=0x22; rd bypass also 0x22.
- Issue dst=1 accepted, next cycle issue src1=1 -> stall=1 until we_b to addr 1; with BYPASS=1 stall drops in writeback cycle, busy[1]=0 after edge.
- Same-cycle writeback to r1 and accepted issue with dst=1 -> busy[1]=1 after edge (set wins).
- ZERO_REG=1: write 0xFF to addr 0, issue dst=0 then src=0 -> rd=0, busy[0]=0, no stall; repeat with DATA_W=16, DEPTH=16.
